// File: rtl/imm_field_packer.sv
`default_nettype none
// ============================================================================
// Module   : imm_field_packer
// Purpose  : Narrows a 16-bit signed value to the 8-bit instruction immediate
//            field for its instruction type. Flags values whose sign-extended
//            field would not reproduce the original. A 2-entry in-order
//            output buffer decouples the two valid/ready handshakes, and a
//            saturating counter tallies accepted overflow entries.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready/in_value[15:0]/in_type[1:0]   - upstream
//            out_valid/out_ready/out_field[7:0]/out_type[1:0]/out_ovf
//                                                            - downstream
//            err_count[ERR_CNT_W-1:0], clr_err               - overflow stats
// Revision : 1.0 - initial release
// ============================================================================
module imm_field_packer #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [15:0]          in_value,
   input  logic [1:0]           in_type,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [7:0]           out_field,
   output logic [1:0]           out_type,
   output logic                 out_ovf,
   output logic [ERR_CNT_W-1:0] err_count,
   input  logic                 clr_err
);

   // Buffer occupancy encoding
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   localparam logic [ERR_CNT_W-1:0] C_ERR_ONE = ERR_CNT_W'(1);

   logic [1:0]  r_occ;
   logic [1:0]  w_occ_nxt;
   logic        r_in_ready;

   // Second (non-head) buffer slot; the head slot is the output registers.
   logic [7:0]  r_tail_field;
   logic [1:0]  r_tail_type;
   logic        r_tail_ovf;

   logic        w_acc;
   logic        w_pop;
   logic        w_fits4;
   logic        w_fits8;
   logic [7:0]  w_enc_field;
   logic        w_enc_ovf;
   logic        w_head_from_in;
   logic        w_head_from_tail;
   logic        w_tail_from_in;

   assign w_acc     = in_valid & r_in_ready;
   assign w_pop     = out_valid & out_ready;
   assign in_ready  = r_in_ready;
   assign out_valid = (r_occ != S_EMPTY);

   // ------------------------------------------------------------------------
   // Encoder: a value fits an N-bit signed field when every bit from N-1
   // upward is a copy of the sign bit.
   // ------------------------------------------------------------------------
   assign w_fits4 = (&in_value[15:3]) | ~(|in_value[15:3]);
   assign w_fits8 = (&in_value[15:7]) | ~(|in_value[15:7]);

   always_comb begin
      w_enc_field = in_value[7:0];
      w_enc_ovf   = 1'b0;
      case (in_type)
         2'b00: begin
            // R-type carries no immediate; low byte passes through unchecked.
            w_enc_field = in_value[7:0];
            w_enc_ovf   = 1'b0;
         end
         2'b01: begin
            w_enc_field = {4'b0000, in_value[3:0]};
            w_enc_ovf   = ~w_fits4;
         end
         default: begin
            w_enc_field = in_value[7:0];
            w_enc_ovf   = ~w_fits8;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Occupancy next-state
   // ------------------------------------------------------------------------
   always_comb begin
      w_occ_nxt = r_occ;
      case (r_occ)
         S_EMPTY: if (w_acc) w_occ_nxt = S_ONE;
         S_ONE: begin
            if (w_acc && !w_pop)      w_occ_nxt = S_FULL;
            else if (!w_acc && w_pop) w_occ_nxt = S_EMPTY;
         end
         S_FULL:  if (w_pop) w_occ_nxt = S_ONE;
         default: w_occ_nxt = S_EMPTY;
      endcase
   end

   // Data movement. A new entry lands in the head when the head is free
   // (empty, or being popped while it is the only entry); otherwise it waits
   // in the tail. Popping a full buffer promotes the tail.
   assign w_head_from_in   = w_acc && ((r_occ == S_EMPTY) || ((r_occ == S_ONE) && w_pop));
   assign w_tail_from_in   = w_acc && (r_occ == S_ONE) && !w_pop;
   assign w_head_from_tail = w_pop && (r_occ == S_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ        <= S_EMPTY;
         r_in_ready   <= 1'b1;
         out_field    <= 8'h00;
         out_type     <= 2'b00;
         out_ovf      <= 1'b0;
         r_tail_field <= 8'h00;
         r_tail_type  <= 2'b00;
         r_tail_ovf   <= 1'b0;
      end else begin
         r_occ      <= w_occ_nxt;
         // Registered so in_ready never depends combinationally on out_ready.
         r_in_ready <= (w_occ_nxt != S_FULL);
         if (w_head_from_in) begin
            out_field <= w_enc_field;
            out_type  <= in_type;
            out_ovf   <= w_enc_ovf;
         end else if (w_head_from_tail) begin
            out_field <= r_tail_field;
            out_type  <= r_tail_type;
            out_ovf   <= r_tail_ovf;
         end
         if (w_tail_from_in) begin
            r_tail_field <= w_enc_field;
            r_tail_type  <= in_type;
            r_tail_ovf   <= w_enc_ovf;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Overflow counter. A clear coinciding with an overflow accept leaves 1 so
   // that event is not lost.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= (w_acc && w_enc_ovf) ? C_ERR_ONE : '0;
      end else if (w_acc && w_enc_ovf && !(&err_count)) begin
         err_count <= err_count + C_ERR_ONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imm_field_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_field_packer
// Purpose  : Scoreboard bench for imm_field_packer. Expected entries are
//            computed from a range-based model when an accept happens and
//            compared in order when the DUT pops them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_field_packer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_value;
   logic [1:0]  in_type;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_field;
   logic [1:0]  out_type;
   logic        out_ovf;
   logic [7:0]  err_count;
   logic        clr_err;

   typedef struct packed {
      logic [7:0] field;
      logic [1:0] typ;
      logic       ovf;
   } ent_t;

   ent_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_err  = 8'h00;
   logic        acc;
   logic        popd;

   imm_field_packer #(.ERR_CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .in_type   (in_type),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_field (out_field),
      .out_type  (out_type),
      .out_ovf   (out_ovf),
      .err_count (err_count),
      .clr_err   (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Independent model: fit is decided by signed range, not by bit patterns.
   function automatic void model(input logic [15:0] v, input logic [1:0] t,
                                 output logic [7:0] f, output logic o);
      int s;
      s = int'($signed(v));
      case (t)
         2'b00:   begin f = v[7:0];             o = 1'b0; end
         2'b01:   begin f = {4'h0, v[3:0]};     o = (s < -8)   || (s > 7);   end
         default: begin f = v[7:0];             o = (s < -128) || (s > 127); end
      endcase
   endfunction

   // Called just after a falling edge with inputs already driven; observes
   // what the next rising edge will do, advances to the next falling edge.
   task automatic tick();
      ent_t       e;
      logic [7:0] f;
      logic       o;
      #1;
      acc  = in_valid && in_ready;
      popd = out_valid && out_ready;
      o    = 1'b0;
      if (popd) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_pop", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("out_field", out_field, e.field);
            chk("out_type",  out_type,  e.typ);
            chk("out_ovf",   out_ovf,   e.ovf);
         end
      end
      if (acc) begin
         model(in_value, in_type, f, o);
         e.field = f; e.typ = in_type; e.ovf = o;
         sb.push_back(e);
      end
      if (clr_err)                               exp_err = (acc && o) ? 8'h01 : 8'h00;
      else if (acc && o && exp_err != 8'hFF)     exp_err = exp_err + 8'h01;
      @(posedge clk);
      @(negedge clk);
      chk("err_count", err_count, exp_err);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
      chk("drain_sb_empty", sb.size(), 0);
      chk("drain_out_valid", out_valid, 0);
   endtask

   logic [15:0] bp_vals [3];
   logic [15:0] one_vals[3];
   int          idx;
   logic        seen_pop;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_value = 16'h0; in_type = 2'b00;
      out_ready = 1'b0; clr_err = 1'b0;
      bp_vals[0]  = 16'h0011; bp_vals[1]  = 16'h0022; bp_vals[2]  = 16'h0033;
      one_vals[0] = 16'h007F; one_vals[1] = 16'hFF80; one_vals[2] = 16'h0080;

      // ---- reset values
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_field", out_field, 8'h00);
      chk("rst_out_type",  out_type,  0);
      chk("rst_out_ovf",   out_ovf,   0);
      chk("rst_err_count", err_count, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- single accept, type 10, 0xFF80
      in_valid = 1'b1; in_type = 2'b10; in_value = 16'hFF80;
      tick();
      in_valid = 1'b0; in_value = 16'h1234;
      chk("lat_out_valid", out_valid, 1);
      chk("lat_out_field", out_field, 8'h80);
      chk("lat_out_ovf",   out_ovf,   0);
      chk("lat_err_count", err_count, 0);
      drain();

      // ---- type 01 boundaries, streamed back to back
      out_ready = 1'b1; in_valid = 1'b1; in_type = 2'b01;
      in_value = 16'h0007; tick();
      chk("t01_7_field", out_field, 8'h07); chk("t01_7_ovf", out_ovf, 0);
      in_value = 16'hFFF8; tick();
      chk("t01_m8_field", out_field, 8'h08); chk("t01_m8_ovf", out_ovf, 0);
      in_value = 16'h0008; tick();
      chk("t01_8_field", out_field, 8'h08); chk("t01_8_ovf", out_ovf, 1);
      in_value = 16'hFFF7; tick();
      chk("t01_m9_field", out_field, 8'h07); chk("t01_m9_ovf", out_ovf, 1);
      drain();
      chk("t01_err_count", err_count, 8'h02);

      // ---- backpressure with three offered values
      out_ready = 1'b0; in_type = 2'b10; idx = 0; seen_pop = 1'b0;
      for (int c = 0; c < 20 && idx < 3; c++) begin
         if (c == 6) out_ready = 1'b1;
         in_valid = 1'b1; in_value = bp_vals[idx];
         tick();
         if (acc) idx++;
         if (acc && idx == 2) chk("bp_in_ready_full", in_ready, 0);
         if (c >= 2 && c < 6) chk("bp_head_hold", out_field, 8'h11);
         if (popd && !seen_pop) begin
            seen_pop = 1'b1;
            chk("bp_pop_no_accept", acc, 0);
            chk("bp_in_ready_after_pop", in_ready, 1);
         end
      end
      chk("bp_all_accepted", idx, 3);
      drain();

      // ---- sustained accept+pop in ONE
      out_ready = 1'b0; in_valid = 1'b1; in_type = 2'b11; in_value = 16'h0080;
      tick();
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         in_value = one_vals[c % 3];
         tick();
         chk("one_acc_and_pop", {acc, popd}, 2'b11);
         chk("one_out_valid", out_valid, 1);
         chk("one_in_ready",  in_ready,  1);
      end
      drain();

      // ---- counter saturation and clear
      out_ready = 1'b1; in_valid = 1'b1; in_type = 2'b01; in_value = 16'h0100;
      for (int c = 0; c < 260; c++) tick();
      chk("err_saturated", err_count, 8'hFF);
      clr_err = 1'b1;
      tick();
      chk("err_clr_with_ovf", err_count, 8'h01);
      in_valid = 1'b0;
      tick();
      chk("err_clr_alone", err_count, 8'h00);
      clr_err = 1'b0;
      drain();

      // ---- reset with a full buffer
      out_ready = 1'b0; in_valid = 1'b1; in_type = 2'b10; in_value = 16'h0042;
      tick(); tick();
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready",  in_ready,  1);
      chk("arst_out_field", out_field, 8'h00);
      sb.delete();
      exp_err = 8'h00;
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("post_rst_no_stale", out_valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imm_field_packer.md
# imm_field_packer

Inverse of the datapath immediate sign extender. It accepts a 16-bit signed value and a 2-bit instruction type, and narrows the value to the 8-bit instruction immediate field. It also checks that sign-extending the narrowed field reproduces the original value. It sits in the program-loader / instruction-build path ahead of instruction memory, uses valid/ready handshakes on both sides, and has a 2-entry output buffer and a saturating overflow counter.

## Interface
- ERR_CNT_W, default 8: width of the overflow event counter.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream offers a value this cycle.
- in_ready  output  1  block can accept; registered, no combinational path from out_ready.
- in_value  input  16  signed value to encode.
- in_type  input  2  instruction type: 00 R, 01 memory, 10 immediate, 11 branch.
- out_valid  output  1  head of the output buffer is valid.
- out_ready  input  1  downstream consumes the head this cycle.
- out_field  output  8  encoded immediate field.
- out_type  output  2  in_type carried with the entry.
- out_ovf  output  1  value not representable in the field for this type.
- err_count  output  ERR_CNT_W  count of accepted entries with ovf = 1; saturating.
- clr_err  input  1  synchronous clear of err_count.

## Operation
- Accept when in_valid and in_ready are both high at a rising edge. Pop when out_valid and out_ready are both high at a rising edge.
- Encoding is combinational on in_value/in_type and is written into the buffer on accept:
  - type 00: field = in_value[7:0], ovf = 0. R-type has no immediate; the low byte is passed through.
  - type 01: fits iff in_value[15:3] are all equal. field = {4'b0000, in_value[3:0]}.
  - type 10 and 11: fits iff in_value[15:7] are all equal. field = in_value[7:0].
  - ovf = !fits. The truncated field is still emitted when ovf = 1.
- Round-trip property for ovf = 0 with type ≠ 00: sign-extending field (4 bits for 01, 8 bits for 10/11) equals in_value.
- Buffer: 2-entry FIFO, strict in-order, with occupancy states EMPTY, ONE, FULL.
  - EMPTY: accept → ONE.
  - ONE: accept only → FULL; pop only → EMPTY; accept and pop together → ONE.
  - FULL: pop → ONE. No accept is possible because in_ready = 0.
- in_ready is the registered value of (next occupancy ≠ FULL). In FULL, a pop raises in_ready only from the next cycle.
- out_field, out_type and out_ovf always show the head entry. When empty they hold their last value; downstream must qualify them with out_valid.
- err_count:
  - Increments by 1 on each accept with ovf = 1 and saturates at all-ones.
  - clr_err alone sets it to 0.
  - clr_err in the same cycle as an ovf accept sets it to 1, so no event is lost.

## Timing
- Reset values (asynchronous): out_valid = 0, in_ready = 1, out_field = 0, out_type = 0, out_ovf = 0, err_count = 0, occupancy = EMPTY.
- Reset mid-operation discards all buffered entries with no pop.
- Latency: an entry accepted at edge N is on the outputs with out_valid = 1 in the cycle after edge N, provided the buffer was EMPTY.
- Throughput: one entry per cycle sustained while out_ready stays high.
- out_valid only falls after a pop that empties the buffer. The head never changes while out_valid = 1 and out_ready = 0.
- in_value/in_type are ignored when no accept occurs.

## Test plan
- Reset then single accept of type 10, value 0xFF80 → next cycle out_valid = 1, out_field = 0x80, out_ovf = 0, err_count = 0.
- Type 01 boundaries:
  - 0x0007 → field 0x07, ovf 0.
  - 0xFFF8 → field 0x08, ovf 0.
  - 0x0008 → field 0x08, ovf 1.
  - 0xFFF7 → field 0x07, ovf 1.
  - err_count = 2 after all four.
- Backpressure: out_ready = 0 with 3 values offered → in_ready low after the 2nd accept. Then hold out_ready = 1 → outputs pop in order, in_ready high one cycle after the first pop, and the 3rd value is accepted.
- Simultaneous accept and pop in ONE for 20 cycles, types 11, values 0x007F / 0xFF80 / 0x0080 → occupancy stays ONE, in order, ovf set only for 0x0080.
- err_count saturation at 0xFF with further ovf accepts stays 0xFF. Then clr_err together with an ovf accept → 1.
- Reset asserted with FULL buffer → out_valid = 0 and in_ready = 1 immediately. After release no stale entry appears.
